// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified memory: CPU priority, DMA starvation guard,
// registered read-owner tag routes mem_rdata back to the issuing master.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,

  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_wstrb,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DATA_W-1:0]   dma_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic [CNT_W-1:0]    cnt_cpu_gnt,
  output logic [CNT_W-1:0]    cnt_dma_gnt,
  output logic [CNT_W-1:0]    cnt_conflict
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e     rd_owner;
  owner_e     owner_nxt;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;
  logic       conflict;
  logic       dma_win;

  // DMA takes the port when alone, or when CPU has starved it long enough.
  assign conflict = cpu_req & dma_req;
  assign dma_win  = dma_req & (~cpu_req | (starve_cnt == LIMIT));
  assign dma_gnt  = dma_win;
  assign cpu_gnt  = cpu_req & ~dma_win;
  assign mem_req  = cpu_gnt | dma_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wstrb = cpu_wstrb;
      end
      dma_gnt: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_wstrb = dma_wstrb;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = {STRB_W{1'b0}};
      end
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (dma_gnt)
      starve_nxt = 8'd0;
    else if (conflict && starve_cnt < LIMIT)
      starve_nxt = starve_cnt + 8'd1;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (cpu_gnt && !cpu_we)
      owner_nxt = OWN_CPU;
    else if (dma_gnt && !dma_we)
      owner_nxt = OWN_DMA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
      rd_owner   <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      rd_owner   <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cpu_gnt  <= '0;
      cnt_dma_gnt  <= '0;
      cnt_conflict <= '0;
    end else begin
      if (cpu_gnt)
        cnt_cpu_gnt <= cnt_cpu_gnt + ONE;
      if (dma_gnt)
        cnt_dma_gnt <= cnt_dma_gnt + ONE;
      if (conflict)
        cnt_conflict <= cnt_conflict + ONE;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dma_rvalid = (rd_owner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized, self-checking bench for mem_arbiter against a
// rule-level reference model with a shadow memory.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0]  cpu_wstrb = 0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req = 0, dma_we = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic [3:0]  dma_wstrb = 0;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 0;
  logic [31:0] cnt_cpu_gnt, cnt_dma_gnt, cnt_conflict;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_model [256];
  logic [31:0] ref_mem [256];

  int          m_lost;
  int          m_pend;
  logic [31:0] m_pdata;
  int          m_ncpu, m_ndma, m_nconf;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .cnt_cpu_gnt(cnt_cpu_gnt), .cnt_dma_gnt(cnt_dma_gnt),
    .cnt_conflict(cnt_conflict)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: synchronous read, byte-strobed write.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b])
            mem_model[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem_model[mem_addr[9:2]];
      end
    end
  end

  // 0 = nobody, 1 = CPU, 2 = DMA
  function automatic int exp_winner();
    if (cpu_req && dma_req) return (m_lost >= LIMIT) ? 2 : 1;
    if (cpu_req) return 1;
    if (dma_req) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_lost = 0; m_pend = 0; m_pdata = 0;
    m_ncpu = 0; m_ndma = 0; m_nconf = 0;
  endtask

  // Advance one clock, updating the reference model with this cycle's winner.
  task automatic tick();
    int w;
    w = exp_winner();
    if (cpu_req && dma_req) m_nconf++;
    m_pend = 0;
    if (w == 1) begin
      m_ncpu++;
      if (dma_req) m_lost++;
      if (cpu_we)
        ref_mem[cpu_addr[9:2]] = merge(ref_mem[cpu_addr[9:2]], cpu_wdata, cpu_wstrb);
      else begin
        m_pend = 1; m_pdata = ref_mem[cpu_addr[9:2]];
      end
    end else if (w == 2) begin
      m_ndma++;
      m_lost = 0;
      if (dma_we)
        ref_mem[dma_addr[9:2]] = merge(ref_mem[dma_addr[9:2]], dma_wdata, dma_wstrb);
      else begin
        m_pend = 2; m_pdata = ref_mem[dma_addr[9:2]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_wstrb = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rvalid cpu=%b dma=%b want 0 0", cpu_rvalid, dma_rvalid);
    end
    checks++;
    if (cnt_cpu_gnt !== 0 || cnt_dma_gnt !== 0 || cnt_conflict !== 0) begin
      failures++;
      $display("FAIL reset_counters got %0d %0d %0d want 0 0 0",
               cnt_cpu_gnt, cnt_dma_gnt, cnt_conflict);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 0) begin
      failures++;
      $display("FAIL reset_idle mem_req=%b addr=%h want 0 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL cpu_read_gnt gnt=%b/%b req=%b addr=%h want 1/0 1 200",
               cpu_gnt, dma_gnt, mem_req, mem_addr);
    end
    tick();
    idle_inputs();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1111_1111 || dma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_data rvalid=%b data=%h dma_rvalid=%b want 1 11111111 0",
               cpu_rvalid, cpu_rdata, dma_rvalid);
    end
    checks++;
    if (cnt_cpu_gnt !== 1) begin
      failures++;
      $display("FAIL cpu_read_cnt got %0d want 1", cnt_cpu_gnt);
    end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_single got rvalid=%b want 0", cpu_rvalid);
    end
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 32'h300;
    dma_wdata = 32'h2222_2222; dma_wstrb = 4'hF;
    #1;
    checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_we !== 1'b1 ||
        mem_wdata !== 32'h2222_2222 || mem_wstrb !== 4'hF) begin
      failures++;
      $display("FAIL dma_write_gnt gnt=%b we=%b wdata=%h wstrb=%h want 1 1 22222222 f",
               dma_gnt, mem_we, mem_wdata, mem_wstrb);
    end
    tick();
    idle_inputs();
    checks++;
    if (mem_model[8'hC0] !== 32'h2222_2222) begin
      failures++;
      $display("FAIL dma_write_mem got %h want 22222222", mem_model[8'hC0]);
    end
    checks++;
    if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL dma_write_rvalid got %b/%b want 0/0", cpu_rvalid, dma_rvalid);
    end
  endtask

  task automatic test_conflict();
    int pat_bad;
    int rv_bad;
    do_reset();
    pat_bad = 0; rv_bad = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
    dma_req = 1; dma_we = 0; dma_addr = 32'h204;
    for (int i = 0; i < 10; i++) begin
      logic want_dma;
      want_dma = (i % 5 == 4);
      #1;
      if (dma_gnt !== want_dma || cpu_gnt !== !want_dma) begin
        pat_bad++;
        $display("FAIL conflict_seq cycle %0d cpu=%b dma=%b want dma=%b",
                 i, cpu_gnt, dma_gnt, want_dma);
      end
      tick();
      if (want_dma ? (dma_rvalid !== 1 || cpu_rvalid !== 0 || dma_rdata !== 32'h2222_2222)
                   : (cpu_rvalid !== 1 || dma_rvalid !== 0 || cpu_rdata !== 32'h1111_1111)) begin
        rv_bad++;
        $display("FAIL conflict_route cycle %0d rv=%b/%b data=%h",
                 i, cpu_rvalid, dma_rvalid, cpu_rdata);
      end
    end
    idle_inputs();
    checks++;
    if (pat_bad != 0) failures++;
    checks++;
    if (rv_bad != 0) failures++;
    checks++;
    if (cnt_conflict !== 10 || cnt_cpu_gnt !== 8 || cnt_dma_gnt !== 2) begin
      failures++;
      $display("FAIL conflict_counters got conf=%0d cpu=%0d dma=%0d want 10 8 2",
               cnt_conflict, cnt_cpu_gnt, cnt_dma_gnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        cpu_req = 1; cpu_addr = 32'h200;
      end else begin
        dma_req = 1; dma_addr = 32'h204;
      end
      tick();
      if (i % 2 == 0) begin
        if (cpu_rvalid !== 1 || dma_rvalid !== 0 || cpu_rdata !== 32'h1111_1111) bad++;
      end else begin
        if (dma_rvalid !== 1 || cpu_rvalid !== 0 || dma_rdata !== 32'h2222_2222) bad++;
      end
      if (bad != 0 && i == 5)
        $display("FAIL b2b_route errors=%0d want 0", bad);
    end
    idle_inputs();
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    dma_req = 1; dma_addr = 32'h204;
    tick();
    idle_inputs();
    checks++;
    if (dma_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got dma_rvalid=%b want 1", dma_rvalid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got dma_rvalid=%b want 0", dma_rvalid);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    #1;
    checks++;
    if (cnt_cpu_gnt !== 0 || cnt_dma_gnt !== 0 || cnt_conflict !== 0) begin
      failures++;
      $display("FAIL midrst_counters got %0d %0d %0d want 0", cnt_cpu_gnt, cnt_dma_gnt, cnt_conflict);
    end
    // Build up starvation, reset, then CPU must win LIMIT conflicts again.
    cpu_req = 1; dma_req = 1;
    repeat (3) tick();
    idle_inputs();
    rst_n = 0;
    #2 rst_n = 1;
    model_reset();
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i <= LIMIT; i++) begin
      #1;
      checks++;
      if (dma_gnt !== (i == LIMIT)) begin
        failures++;
        $display("FAIL midrst_starve cycle %0d dma_gnt=%b want %b", i, dma_gnt, i == LIMIT);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int  bad_g, bad_r;
    logic cpu_hold, dma_hold;
    do_reset();
    bad_g = 0; bad_r = 0; cpu_hold = 0; dma_hold = 0;
    for (int i = 0; i < 400; i++) begin
      int w;
      if (!cpu_hold) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = $urandom_range(0, 1);
        cpu_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        cpu_wdata = $urandom;
        cpu_wstrb = 4'($urandom_range(0, 15));
      end
      if (!dma_hold) begin
        dma_req = ($urandom_range(0, 2) != 0);
        dma_we = $urandom_range(0, 1);
        dma_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dma_wdata = $urandom;
        dma_wstrb = 4'($urandom_range(0, 15));
      end
      #1;
      w = exp_winner();
      if (cpu_gnt !== (w == 1) || dma_gnt !== (w == 2) || mem_req !== (w != 0) ||
          mem_addr !== (w == 1 ? cpu_addr : w == 2 ? dma_addr : 32'd0) ||
          mem_we !== (w == 1 ? cpu_we : w == 2 ? dma_we : 1'b0)) begin
        bad_g++;
        if (bad_g < 5)
          $display("FAIL rand_gnt cycle %0d gnt=%b/%b addr=%h want winner %0d",
                   i, cpu_gnt, dma_gnt, mem_addr, w);
      end
      cpu_hold = cpu_req && (w != 1);
      dma_hold = dma_req && (w != 2);
      tick();
      if (cpu_rvalid !== (m_pend == 1) || dma_rvalid !== (m_pend == 2) ||
          (m_pend != 0 && cpu_rdata !== m_pdata)) begin
        bad_r++;
        if (bad_r < 5)
          $display("FAIL rand_rdata cycle %0d rv=%b/%b data=%h want owner %0d data %h",
                   i, cpu_rvalid, dma_rvalid, cpu_rdata, m_pend, m_pdata);
      end
    end
    idle_inputs();
    checks++;
    if (bad_g != 0) failures++;
    checks++;
    if (bad_r != 0) failures++;
    checks++;
    if (cnt_cpu_gnt !== m_ncpu || cnt_dma_gnt !== m_ndma || cnt_conflict !== m_nconf) begin
      failures++;
      $display("FAIL rand_counters got %0d %0d %0d want %0d %0d %0d",
               cnt_cpu_gnt, cnt_dma_gnt, cnt_conflict, m_ncpu, m_ndma, m_nconf);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    mem_model[8'h80] = 32'h1111_1111; ref_mem[8'h80] = 32'h1111_1111;
    mem_model[8'h81] = 32'h2222_2222; ref_mem[8'h81] = 32'h2222_2222;
    model_reset();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
